uart_rx_param: RTL and testbench

- Parametrised UART receive engine; successor to the fixed 8N1 receiver.
- Configurable data width, parity mode, stop-bit count, oversampling rate and runtime baud selection.
- Adds input synchronisation, majority-vote sampling, false-start rejection, and parity/framing error flags.
- Sits between the rs232_rx pin and any byte consumer that latches data_byte on rx_done.

---
 rtl/uart_rx_param.sv | 137 +++++++++++++
 tb/tb_uart_rx_param.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, runtime baud select, 3-sample
// majority vote per bit, false-start rejection, parity and framing error flags.
module uart_rx_param #(
    parameter int CLK_FREQ   = 50000000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           baud_set,
    input  logic                 rs232_rx,
    output logic [DATA_BITS-1:0] data_byte,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int TW = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    function automatic logic [31:0] div_term(input logic [2:0] sel);
        int baud;
        case (sel)
            3'd0:    baud = 9600;
            3'd1:    baud = 19200;
            3'd2:    baud = 38400;
            3'd3:    baud = 57600;
            3'd4:    baud = 115200;
            3'd5:    baud = 230400;
            3'd6:    baud = 460800;
            default: baud = 921600;
        endcase
        return 32'((CLK_FREQ + baud * OVERSAMPLE / 2) / (baud * OVERSAMPLE) - 1);
    endfunction

    state_t               state, next_state;
    logic                 rx_s1, rx_s2, rx_prev;
    logic [31:0]          div_cnt, div_max;
    logic [TW-1:0]        tick_cnt;
    logic [3:0]           bit_cnt;
    logic [1:0]           samp;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, stop_bad, perr_calc;
    logic                 fall, tick, samp0, samp1, decide, bound, vote;
    logic                 last_data, last_stop;

    assign fall      = rx_prev & ~rx_s2;
    assign tick      = (state != S_IDLE) && (div_cnt == div_max);
    // tick_cnt holds the ticks already elapsed in the bit, so the update from
    // k-1 to k is "tick k"; samples land on ticks OS/2-1, OS/2, OS/2+1
    assign samp0     = tick && (tick_cnt == TW'(OVERSAMPLE / 2 - 2));
    assign samp1     = tick && (tick_cnt == TW'(OVERSAMPLE / 2 - 1));
    assign decide    = tick && (tick_cnt == TW'(OVERSAMPLE / 2));
    assign bound     = tick && (tick_cnt == TW'(OVERSAMPLE - 1));
    assign vote      = (samp[0] & samp[1]) | (samp[0] & rx_s2) | (samp[1] & rx_s2);
    assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
    assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));
    assign busy      = (state != S_IDLE) | rx_done;

    always_comb begin
        perr_calc = 1'b0;
        if (PARITY == 1)      perr_calc = ~(^shreg ^ par_bit);
        else if (PARITY == 2) perr_calc = ^shreg ^ par_bit;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (fall) next_state = S_START;
            S_START:  if (decide && vote) next_state = S_IDLE;
                      else if (bound)     next_state = S_DATA;
            S_DATA:   if (bound && last_data) next_state = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (bound) next_state = S_STOP;
            // leave at the last stop-bit vote so a following start edge is never missed
            S_STOP:   if (decide && last_stop) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            div_cnt    <= '0;
            div_max    <= '0;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            samp       <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            stop_bad   <= 1'b0;
            data_byte  <= '0;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1   <= rs232_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            state   <= next_state;
            rx_done <= 1'b0;
            if (state == S_IDLE) begin
                div_cnt  <= '0;
                tick_cnt <= '0;
                bit_cnt  <= '0;
                stop_bad <= 1'b0;
                if (fall) div_max <= div_term(baud_set);
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 32'd1;
                if (tick) tick_cnt <= bound ? '0 : tick_cnt + 1'b1;
                if (samp0) samp[0] <= rx_s2;
                if (samp1) samp[1] <= rx_s2;
                if (decide) begin
                    case (state)
                        S_DATA:   shreg <= {vote, shreg[DATA_BITS-1:1]};
                        S_PARITY: par_bit <= vote;
                        S_STOP:   if (!vote) stop_bad <= 1'b1;
                        default:  ;
                    endcase
                end
                if (bound && state == S_DATA) bit_cnt <= last_data ? '0 : bit_cnt + 4'd1;
                if (bound && state == S_STOP) bit_cnt <= bit_cnt + 4'd1;
                if (state == S_STOP && decide && last_stop) begin
                    rx_done    <= 1'b1;
                    data_byte  <= shreg;
                    parity_err <= perr_calc;
                    frame_err  <= stop_bad | ~vote;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 instance and an 8E2 instance driven by a
// bit-level serial sender, with expected words queued per instance.
module tb_uart_rx_param;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] bs0, bs2;
    logic       rx0, rx2;
    logic [7:0] d0, d2;
    logic       done0, pe0, fe0, busy0;
    logic       done2, pe2, fe2, busy2;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_FREQ(50000000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                    .OVERSAMPLE(16)) dut0 (
        .clk(clk), .rst(rst), .baud_set(bs0), .rs232_rx(rx0), .data_byte(d0),
        .rx_done(done0), .parity_err(pe0), .frame_err(fe0), .busy(busy0));

    uart_rx_param #(.CLK_FREQ(50000000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
                    .OVERSAMPLE(16)) dut2 (
        .clk(clk), .rst(rst), .baud_set(bs2), .rs232_rx(rx2), .data_byte(d2),
        .rx_done(done2), .parity_err(pe2), .frame_err(fe2), .busy(busy2));

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        int         dut;
        logic [7:0] word;
        logic       pbit;
        logic [1:0] stops;
        logic [2:0] baud;
        int         pct;
        int         gap;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    exp_t q0[$], q2[$];
    vec_t tbl[9];
    int   n_checks = 0, n_fail = 0;
    int   done_cnt0 = 0, done_cnt2 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int bit_clks(input logic [2:0] sel);
        int baud;
        case (sel)
            3'd0: baud = 9600;    3'd1: baud = 19200;
            3'd2: baud = 38400;   3'd3: baud = 57600;
            3'd4: baud = 115200;  3'd5: baud = 230400;
            3'd6: baud = 460800;  default: baud = 921600;
        endcase
        return ((50000000 + baud * 8) / (baud * 16)) * 16;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) rx0 = v; else rx2 = v;
    endtask

    // Drives one frame; baud select is scrambled after the start bit, which
    // the receiver must ignore. Leaves the line at the final stop-bit level.
    task automatic send_frame(input int which, input logic [7:0] word, input logic pbit,
                              input logic [1:0] stops, input int cpb);
        set_line(which, 1'b0);
        wait_clks(cpb);
        if (which == 0) bs0 = 3'($urandom); else bs2 = 3'($urandom);
        for (int i = 0; i < 8; i++) begin
            set_line(which, word[i]);
            wait_clks(cpb);
        end
        if (which == 2) begin
            set_line(which, pbit);
            wait_clks(cpb);
        end
        set_line(which, stops[0]);
        wait_clks(cpb);
        if (which == 2) begin
            set_line(which, stops[1]);
            wait_clks(cpb);
        end
    endtask

    task automatic check_pending(input int which);
        int n;
        n = (which == 0) ? q0.size() : q2.size();
        check($sformatf("dut%0d missing rx_done count", which), n, 0);
        if (which == 0) q0.delete(); else q2.delete();
    endtask

    task automatic apply_row(input vec_t v);
        exp_t e;
        e.data = v.exp_data;
        e.perr = v.exp_perr;
        e.ferr = v.exp_ferr;
        if (v.dut == 0) q0.push_back(e); else q2.push_back(e);
        @(negedge clk);
        if (v.dut == 0) bs0 = v.baud; else bs2 = v.baud;
        send_frame(v.dut, v.word, v.pbit, v.stops, bit_clks(v.baud) * v.pct / 100);
        set_line(v.dut, 1'b1);
        wait_clks(bit_clks(v.baud) * v.gap);
        check_pending(v.dut);
    endtask

    // Scoreboards: every rx_done is matched against the next queued frame.
    initial begin
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done0) begin
                done_cnt0++;
                check("dut0 rx_done single cycle", prev, 0);
                check("dut0 busy during rx_done", busy0, 1);
                if (q0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL dut0 unexpected rx_done: data %0h, required none", d0);
                end else begin
                    e = q0.pop_front();
                    check("dut0 data_byte", d0, e.data);
                    check("dut0 parity_err", pe0, e.perr);
                    check("dut0 frame_err", fe0, e.ferr);
                end
            end
            prev = done0;
        end
    end

    initial begin
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done2) begin
                done_cnt2++;
                check("dut2 rx_done single cycle", prev, 0);
                check("dut2 busy during rx_done", busy2, 1);
                if (q2.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL dut2 unexpected rx_done: data %0h, required none", d2);
                end else begin
                    e = q2.pop_front();
                    check("dut2 data_byte", d2, e.data);
                    check("dut2 parity_err", pe2, e.perr);
                    check("dut2 frame_err", fe2, e.ferr);
                end
            end
            prev = done2;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //           dut word   pbit stops  baud pct gap exp    perr  ferr
        tbl[0] = '{2, 8'h3C, 1'b1, 2'b11, 3'd4, 100, 2, 8'h3C, 1'b1, 1'b0};
        tbl[1] = '{2, 8'h3C, 1'b0, 2'b11, 3'd4, 100, 2, 8'h3C, 1'b0, 1'b0};
        tbl[2] = '{0, 8'h00, 1'b0, 2'b11, 3'd4,  98, 0, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{0, 8'hFF, 1'b0, 2'b11, 3'd4,  98, 0, 8'hFF, 1'b0, 1'b0};
        tbl[4] = '{0, 8'h81, 1'b0, 2'b11, 3'd4,  98, 2, 8'h81, 1'b0, 1'b0};
        tbl[5] = '{0, 8'h5A, 1'b0, 2'b11, 3'd7, 100, 2, 8'h5A, 1'b0, 1'b0};
        tbl[6] = '{2, 8'hC4, 1'b1, 2'b10, 3'd6, 100, 2, 8'hC4, 1'b0, 1'b1};
        tbl[7] = '{0, 8'h3E, 1'b0, 2'b11, 3'd7, 100, 2, 8'h3E, 1'b0, 1'b0};
        tbl[8] = '{0, 8'h12, 1'b0, 2'b11, 3'd7, 100, 2, 8'h12, 1'b0, 1'b0};

        rst = 1'b1; rx0 = 1'b1; rx2 = 1'b1; bs0 = 3'd0; bs2 = 3'd0;
        wait_clks(3);
        check("reset data_byte", {d2, d0}, 0);
        check("reset rx_done", {done2, done0}, 0);
        check("reset parity_err", {pe2, pe0}, 0);
        check("reset frame_err", {fe2, fe0}, 0);
        check("reset busy", {busy2, busy0}, 0);
        rst = 1'b0;
        wait_clks(5);

        fork
            begin : slow_8n1
                exp_t e;
                e.data = 8'hA5; e.perr = 1'b0; e.ferr = 1'b0;
                q0.push_back(e);
                fork
                    begin
                        @(negedge clk);
                        bs0 = 3'd0;
                        send_frame(0, 8'hA5, 1'b0, 2'b11, bit_clks(3'd0));
                        set_line(0, 1'b1);
                        wait_clks(100);
                    end
                    begin
                        int n = 0, w = 0;
                        while (!busy0 && w < 2000) begin @(negedge clk); w++; end
                        while (busy0 && n < 60000) begin @(negedge clk); n++; end
                        // start edge to final stop vote is 153 ticks of 326 clk
                        n_checks++;
                        if (n < 49779 || n > 49979) begin
                            n_fail++;
                            $display("FAIL busy length at 9600: got %0d clk, expected 49879 +/- 100", n);
                        end
                    end
                join
                check_pending(0);
            end
            begin : parity_and_random
                apply_row(tbl[0]);
                apply_row(tbl[1]);
                apply_row(tbl[6]);
                for (int k = 0; k < 16; k++) begin
                    vec_t v;
                    int   ones, flip;
                    v.dut   = 2;
                    v.word  = 8'($urandom);
                    ones    = $countones(v.word);
                    flip    = ($urandom_range(0, 3) == 0) ? 1 : 0;
                    v.pbit  = ((ones + flip) % 2) == 1;
                    v.stops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
                    v.baud  = 3'($urandom_range(6, 7));
                    v.pct   = 100;
                    v.gap   = $urandom_range(1, 2);
                    v.exp_data = v.word;
                    v.exp_perr = ((ones + (v.pbit ? 1 : 0)) % 2) != 0;
                    v.exp_ferr = (v.stops != 2'b11);
                    apply_row(v);
                end
            end
        join

        // back-to-back frames from a 2% fast sender
        for (int i = 2; i <= 5; i++) apply_row(tbl[i]);

        begin : glitch
            logic [7:0] dprev;
            int cnt, w;
            @(negedge clk);
            bs0 = 3'd7; dprev = d0; cnt = done_cnt0;
            rx0 = 1'b0;
            wait_clks(12);
            check("glitch busy asserted", busy0, 1);
            rx0 = 1'b1;
            w = 0;
            while (busy0 && w < 48) begin @(negedge clk); w++; end
            check("glitch busy cleared within a bit", busy0, 0);
            wait_clks(48);
            check("glitch data_byte held", d0, dprev);
            check("glitch no rx_done", done_cnt0 - cnt, 0);
        end

        begin : line_break
            exp_t e;
            int cnt;
            e.data = 8'h55; e.perr = 1'b0; e.ferr = 1'b1;
            q0.push_back(e);
            @(negedge clk);
            bs0 = 3'd7;
            send_frame(0, 8'h55, 1'b0, 2'b00, 48);
            wait_clks(48);
            check_pending(0);
            cnt = done_cnt0;
            wait_clks(48 * 30);
            check("break no further rx_done", done_cnt0 - cnt, 0);
            check("break busy idle", busy0, 0);
            check("break frame_err held", fe0, 1);
            rx0 = 1'b1;
            wait_clks(96);
            apply_row(tbl[7]);
        end

        begin : mid_reset
            logic [7:0] w;
            int cnt;
            w = 8'hC3; cnt = done_cnt0;
            @(negedge clk);
            bs0 = 3'd7;
            rx0 = 1'b0;
            wait_clks(48);
            for (int i = 0; i < 4; i++) begin
                rx0 = w[i];
                wait_clks(48);
            end
            rst = 1'b1;
            #1;
            check("mid-reset data_byte", d0, 0);
            check("mid-reset flags", {done0, pe0, fe0}, 0);
            check("mid-reset busy", busy0, 0);
            rx0 = 1'b1;
            wait_clks(5);
            rst = 1'b0;
            wait_clks(100);
            check("mid-reset no rx_done", done_cnt0 - cnt, 0);
            apply_row(tbl[8]);
        end

        wait_clks(20);
        check("final dut0 queue", q0.size(), 0);
        check("final dut2 queue", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
